// File: rtl/im_port_arbiter.sv
// Single-port instruction-memory arbiter: loader-only BOOT phase, then RUN phase
// with fetch priority and a burst counter that bounds how long a loader write can wait.
module im_port_arbiter #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ack,
   input  logic              ld_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              booted,
   output logic              im_en_write,
   output logic [ADDR_W-1:0] im_address,
   output logic [DATA_W-1:0] im_data_in,
   input  logic [DATA_W-1:0] im_data_out
);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

   state_t            r_state;
   logic [3:0]        r_bcnt;
   logic              r_rd_valid;
   logic              w_ld_ack;
   logic              w_rd_gnt;
   logic              w_starved;

   assign w_starved = (r_bcnt == MAX_BURST_C);

   // Grant decision: BOOT serves only the loader; RUN favours fetch unless the loader is starved
   always_comb begin
      w_ld_ack = 1'b0;
      w_rd_gnt = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_ld_ack = ld_req;
         end
         ST_RUN: begin
            if (ld_req && (!rd_req || w_starved)) begin
               w_ld_ack = 1'b1;
            end else if (rd_req) begin
               w_rd_gnt = 1'b1;
            end else begin
               w_ld_ack = 1'b0;
               w_rd_gnt = 1'b0;
            end
         end
         default: begin
            w_ld_ack = 1'b0;
            w_rd_gnt = 1'b0;
         end
      endcase
   end

   // IM port mux; an idle cycle drives all-zero address and data
   always_comb begin
      im_en_write = w_ld_ack;
      im_address  = {ADDR_W{1'b0}};
      im_data_in  = {DATA_W{1'b0}};
      if (w_ld_ack) begin
         im_address = ld_addr;
         im_data_in = ld_data;
      end else if (w_rd_gnt) begin
         im_address = rd_addr;
      end else begin
         im_address = {ADDR_W{1'b0}};
      end
   end

   // Phase FSM, burst counter and read-return valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_bcnt     <= 4'd0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_gnt;
         case (r_state)
            ST_BOOT: begin
               if (ld_done) begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
         if (!ld_req || w_ld_ack) begin
            r_bcnt <= 4'd0;
         end else if (w_rd_gnt) begin
            r_bcnt <= r_bcnt + 4'd1;
         end
      end
   end

   assign ld_ack   = w_ld_ack;
   assign rd_gnt   = w_rd_gnt;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_valid ? im_data_out : {DATA_W{1'b0}};
   assign booted   = (r_state == ST_RUN);

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed bench for im_port_arbiter with a behavioural 1024 x 16 IM model.
module tb_im_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        ld_req;
   logic [9:0]  ld_addr;
   logic [15:0] ld_data;
   logic        ld_ack;
   logic        ld_done;
   logic        rd_req;
   logic [9:0]  rd_addr;
   logic        rd_gnt;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        booted;
   logic        im_en_write;
   logic [9:0]  im_address;
   logic [15:0] im_data_in;
   logic [15:0] im_data_out;

   logic [15:0] mem [0:1023];
   logic [15:0] vals [0:3];
   int          checks;
   int          errors;

   im_port_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack), .ld_done(ld_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .booted(booted),
      .im_en_write(im_en_write), .im_address(im_address), .im_data_in(im_data_in),
      .im_data_out(im_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IM model: synchronous write, registered read data one cycle later
   always @(posedge clk) begin
      if (im_en_write) mem[im_address] <= im_data_in;
      im_data_out <= mem[im_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      im_data_out = 16'h0000;
      vals[0] = 16'h0001; vals[1] = 16'h0011; vals[2] = 16'h0111; vals[3] = 16'h1111;
      rst_n = 1'b0; ld_req = 1'b0; ld_addr = 10'd0; ld_data = 16'h0000; ld_done = 1'b0;
      rd_req = 1'b0; rd_addr = 10'd0;
      #3;
      chk("rst_ld_ack", ld_ack, 1'b0);
      chk("rst_rd_gnt", rd_gnt, 1'b0);
      chk("rst_rd_valid", rd_valid, 1'b0);
      chk("rst_booted", booted, 1'b0);
      chk("rst_im_en", im_en_write, 1'b0);
      chk("rst_im_addr", im_address, 10'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Boot load with a fetch request pending at address 5
      for (int i = 0; i < 4; i++) begin
         ld_req = 1'b1; ld_addr = 10'(i); ld_data = vals[i];
         rd_req = 1'b1; rd_addr = 10'd5;
         #1;
         chk("boot_ld_ack", ld_ack, 1'b1);
         chk("boot_im_en", im_en_write, 1'b1);
         chk("boot_im_addr", im_address, 10'(i));
         chk("boot_im_data", im_data_in, vals[i]);
         chk("boot_rd_gnt", rd_gnt, 1'b0);
         chk("boot_rd_valid", rd_valid, 1'b0);
         chk("boot_booted", booted, 1'b0);
         tick();
      end

      // Write and ld_done in the same BOOT cycle
      ld_addr = 10'd4; ld_data = 16'h2222; ld_done = 1'b1;
      #1;
      chk("done_ld_ack", ld_ack, 1'b1);
      chk("done_im_en", im_en_write, 1'b1);
      chk("done_im_data", im_data_in, 16'h2222);
      chk("done_rd_gnt", rd_gnt, 1'b0);
      tick();
      ld_req = 1'b0; ld_done = 1'b0;
      #1;
      chk("run_booted", booted, 1'b1);
      chk("run_first_gnt", rd_gnt, 1'b1);
      chk("run_first_addr", im_address, 10'd5);
      chk("run_first_en", im_en_write, 1'b0);
      chk("run_rd_valid0", rd_valid, 1'b0);
      tick();

      // Back-to-back reads of the loaded words
      for (int i = 0; i < 4; i++) begin
         rd_req = 1'b1; rd_addr = 10'(i);
         #1;
         chk("b2b_gnt", rd_gnt, 1'b1);
         chk("b2b_addr", im_address, 10'(i));
         chk("b2b_valid", rd_valid, 1'b1);
         chk("b2b_data", rd_data, (i == 0) ? 16'h0000 : vals[i-1]);
         tick();
      end
      rd_req = 1'b0;
      #1;
      chk("b2b_last_valid", rd_valid, 1'b1);
      chk("b2b_last_data", rd_data, vals[3]);
      chk("idle_addr", im_address, 10'd0);
      tick();
      chk("idle_valid", rd_valid, 1'b0);
      chk("idle_data", rd_data, 16'h0000);

      // Starvation guard: four fetch grants, then the loader wins
      rd_req = 1'b1; rd_addr = 10'd1;
      ld_req = 1'b1; ld_addr = 10'h3FF; ld_data = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("starve_rd_gnt", rd_gnt, 1'b1);
         chk("starve_ld_ack", ld_ack, 1'b0);
         tick();
      end
      #1;
      chk("guard_ld_ack", ld_ack, 1'b1);
      chk("guard_rd_gnt", rd_gnt, 1'b0);
      chk("guard_addr", im_address, 10'h3FF);
      chk("guard_data", im_data_in, 16'h4444);
      tick();
      ld_req = 1'b0; rd_addr = 10'h3FF;
      #1;
      chk("resume_gnt", rd_gnt, 1'b1);
      chk("resume_valid0", rd_valid, 1'b0);
      tick();
      rd_req = 1'b0;
      #1;
      chk("readback_valid", rd_valid, 1'b1);
      chk("readback_data", rd_data, 16'h4444);
      tick();

      // Reset in the cycle after a read grant
      rd_req = 1'b1; rd_addr = 10'd0;
      #1;
      chk("pre_rst_gnt", rd_gnt, 1'b1);
      tick();
      chk("pre_rst_valid", rd_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", rd_valid, 1'b0);
      chk("mid_rst_data", rd_data, 16'h0000);
      chk("mid_rst_booted", booted, 1'b0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("post_rst_gnt", rd_gnt, 1'b0);
         chk("post_rst_booted", booted, 1'b0);
         tick();
      end
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      #1;
      chk("reboot_booted", booted, 1'b1);
      chk("reboot_gnt", rd_gnt, 1'b1);
      tick();
      rd_req = 1'b0;
      #1;
      chk("reboot_valid", rd_valid, 1'b1);
      chk("reboot_data", rd_data, vals[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
